uart_rx_ctrl: RTL and testbench

- Receive controller for the UART RX path.
- Synchronises the serial input and generates per-bit sample ticks from the programmed baud divisor.
- Sequences start/data/stop reception with a state machine, drives the bit counter, assembles the byte and presents it on a valid/ack handshake.
- Sits between the uart_combine top level (sel, rx_en, baud) and the host-side byte interface.

---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/uart_rx_baud_gen.sv | 43 ++++
 rtl/uart_rx_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame geometry defaults,
// bit counter width and the receive state encoding.
package uart_rx_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int BAUD_W_DEF    = 20;
  localparam int MIN_BAUD_DEF  = 15;
  localparam int BIT_CNT_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_baud_gen.sv
// Loadable baud down-counter: ticks when it reaches zero while enabled and
// reloads period-1, so ticks are spaced one bit time apart.
module uart_rx_baud_gen
  import uart_rx_pkg::*;
#(
  parameter int BAUD_W = BAUD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic              load,
  input  logic [BAUD_W-1:0] load_val,
  input  logic [BAUD_W-1:0] period,
  output logic              tick
);

  logic [BAUD_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (tick) begin
      cnt_d = period - BAUD_W'(1);
    end else if (en) begin
      cnt_d = cnt_q - BAUD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: rxd synchroniser, start/data/stop sequencing,
// byte assembly and a valid/ack handshake towards the host.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int BAUD_W      = BAUD_W_DEF,
  parameter int MIN_BAUD    = MIN_BAUD_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel,
  input  logic                 rx_en,
  input  logic [BAUD_W-1:0]    baud,
  input  logic                 rxd,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS);
  localparam logic [BIT_CNT_W-1:0] STOP_IDX  = BIT_CNT_W'(DATA_BITS + 1);

  rx_state_e                state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     rxd_prev_q;
  logic [DATA_BITS-1:0]     shift_q, shift_d;
  logic [DATA_BITS-1:0]     data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     ferr_q, ferr_d;
  logic                     ovr_q, ovr_d;
  logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                     rxd_s, run, tick, cnt_load, cnt_clear;

  assign rxd_s = sync_q[SYNC_STAGES-1];
  assign run   = sel && rx_en && (baud >= BAUD_W'(MIN_BAUD));

  uart_rx_baud_gen #(.BAUD_W(BAUD_W)) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q != IDLE),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (baud >> 1),
    .period   (baud),
    .tick     (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    bit_cnt_d = bit_cnt_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    cnt_load  = 1'b0;
    cnt_clear = 1'b0;
    if (rx_ack) valid_d = 1'b0;
    // Losing enable, select or a legal divisor mid-frame drops the frame silently.
    if (state_q != IDLE && !run) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      cnt_clear = 1'b1;
      if (!sel) valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = '0;
          if (run && !rxd_s && rxd_prev_q) begin
            cnt_load = 1'b1;
            state_d  = START;
          end
        end
        START: if (tick) begin
          if (!rxd_s) begin
            state_d   = DATA;
            bit_cnt_d = BIT_CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
        DATA: if (tick) begin
          shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == LAST_DATA) state_d = STOP;
        end
        STOP: if (tick) begin
          bit_cnt_d = STOP_IDX;
          if (rxd_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
        BREAK: if (rxd_s) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sync_q     <= '1;
      rxd_prev_q <= 1'b1;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd};
      rxd_prev_q <= rxd_s;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: stimulus pushes expected receive
// events into a queue, a negedge monitor pops and compares them.
module tb_uart_rx_ctrl;

  localparam int BW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sel = 1'b1;
  logic          rx_en = 1'b1;
  logic          rxd = 1'b1;
  logic          rx_ack = 1'b0;
  logic [BW-1:0] baud = 20'd16;
  logic [7:0]    rx_data;
  logic          rx_valid, frame_err, overrun, busy;
  logic [3:0]    bit_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       ovr;
    int         at;
  } exp_t;

  exp_t       exp_q[$];
  logic       model_valid = 1'b0;
  logic [7:0] model_data = 8'h00;
  logic       prev_valid = 1'b0;

  uart_rx_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .rx_en     (rx_en),
    .baud      (baud),
    .rxd       (rxd),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // A receive event is any byte landing or a framing error being flagged.
  always @(negedge clk) begin
    exp_t e;
    if (frame_err || overrun || (rx_valid && !prev_valid)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {29'd0, frame_err, overrun, rx_valid}, 0);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.at);
        check("frame_err", frame_err, e.ferr);
        check("overrun", overrun, e.ovr);
        check("rx_data", rx_data, e.data);
        if (!e.ferr) check("rx_valid", rx_valid, 1);
      end
    end
    prev_valid <= rx_valid;
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    goto(cyc + n);
  endtask

  // Reference timing: edge seen after 2 sync cycles, start sample half a bit
  // later, stop sample nine bits after that, flags one cycle later.
  task automatic expect_good(input logic [7:0] d, input int b, input int e0);
    exp_t e;
    e.data = d; e.ferr = 1'b0; e.ovr = model_valid; e.at = e0 + 4 + b / 2 + 9 * b;
    exp_q.push_back(e);
    model_valid = 1'b1;
    model_data  = d;
  endtask

  task automatic expect_ferr(input int b, input int e0);
    exp_t e;
    e.data = model_data; e.ferr = 1'b1; e.ovr = 1'b0; e.at = e0 + 4 + b / 2 + 9 * b;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int b, input int e0);
    goto(e0);
    rxd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      goto(e0 + (i + 1) * b);
      rxd = d[i];
    end
    goto(e0 + 9 * b);
    rxd = stop_b;
    goto(e0 + 10 * b);
  endtask

  task automatic good(input logic [7:0] d, input int b);
    int e0;
    e0 = cyc;
    expect_good(d, b, e0);
    send_frame(d, 1'b1, b, e0);
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    goto(cyc + 1);
    rx_ack = 1'b0;
    model_valid = 1'b0;
  endtask

  initial begin
    int e0, b, busy_seen;
    logic [7:0] d;
    logic bad;

    // Reset state
    #1 rst = 1'b0;
    #3;
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    goto(3);
    rst = 1'b1;
    idle(3);

    // Good frame 0xA5, then ack
    e0 = cyc;
    expect_good(8'hA5, 16, e0);
    fork
      send_frame(8'hA5, 1'b1, 16, e0);
      begin
        goto(e0 + 155); @(negedge clk);
        check("valid_before_stop", rx_valid, 0);
        goto(e0 + 156); @(negedge clk);
        check("valid_after_stop", rx_valid, 1);
      end
    join
    do_ack();
    @(negedge clk);
    check("valid_after_ack", rx_valid, 0);
    idle(4);

    // Glitch on start: 4 low cycles
    e0 = cyc;
    rxd = 1'b0;
    goto(e0 + 4);
    rxd = 1'b1;
    goto(e0 + 5); @(negedge clk);
    check("glitch_busy", busy, 1);
    goto(e0 + 12); @(negedge clk);
    check("glitch_idle", busy, 0);
    idle(10);

    // Framing error, held-low line, then recovery with 0x55
    e0 = cyc;
    expect_ferr(16, e0);
    send_frame(8'h3C, 1'b0, 16, e0);
    goto(e0 + 190); @(negedge clk);
    check("break_busy", busy, 1);
    check("break_rx_data", rx_data, 8'hA5);
    goto(e0 + 200);
    rxd = 1'b1;
    goto(e0 + 205); @(negedge clk);
    check("break_exit", busy, 0);
    good(8'h55, 16);
    do_ack();
    idle(4);

    // Overrun, then ack colliding with a stop sample
    good(8'h11, 16);
    good(8'h22, 16);
    @(negedge clk);
    check("ovr_rx_data", rx_data, 8'h22);
    check("ovr_rx_valid", rx_valid, 1);
    e0 = cyc;
    expect_good(8'h33, 16, e0);
    fork
      send_frame(8'h33, 1'b1, 16, e0);
      begin
        goto(e0 + 155);
        rx_ack = 1'b1;
        goto(e0 + 156);
        rx_ack = 1'b0;
      end
    join
    @(negedge clk);
    check("collision_valid", rx_valid, 1);
    idle(4);

    // Divisor below minimum: never leaves IDLE
    baud = 20'd14;
    busy_seen = 0;
    for (int i = 0; i < 100; i++) begin
      rxd = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (busy) busy_seen++;
      @(posedge clk); #1;
    end
    check("bad_baud_busy_cycles", busy_seen, 0);
    rxd = 1'b1;
    idle(4);
    baud = 20'd16;
    idle(2);

    // rx_en abort mid-DATA keeps rx_valid
    e0 = cyc;
    fork
      send_frame(8'h9C, 1'b1, 16, e0);
      begin
        goto(e0 + 64); @(negedge clk);
        check("abort_bit_cnt_before", bit_cnt, 4);
        goto(e0 + 65);
        rx_en = 1'b0;
        goto(e0 + 66); @(negedge clk);
        check("abort_en_busy", busy, 0);
        check("abort_en_bit_cnt", bit_cnt, 0);
        check("abort_en_valid", rx_valid, 1);
        check("abort_en_data", rx_data, 8'h33);
      end
    join
    rx_en = 1'b1;
    idle(4);

    // sel abort mid-DATA clears rx_valid
    e0 = cyc;
    fork
      send_frame(8'h9C, 1'b1, 16, e0);
      begin
        goto(e0 + 65);
        sel = 1'b0;
        goto(e0 + 66); @(negedge clk);
        check("abort_sel_busy", busy, 0);
        check("abort_sel_valid", rx_valid, 0);
        check("abort_sel_data", rx_data, 8'h33);
      end
    join
    model_valid = 1'b0;
    sel = 1'b1;
    idle(4);

    // Reset during STOP discards the frame
    good(8'h6B, 16);
    idle(2);
    e0 = cyc;
    fork
      send_frame(8'h77, 1'b1, 16, e0);
      begin
        goto(e0 + 150);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_bit_cnt", bit_cnt, 0);
        goto(e0 + 153);
        rst = 1'b1;
        goto(e0 + 154); @(negedge clk);
        check("post_rst_idle", busy, 0);
      end
    join
    model_valid = 1'b0;
    model_data  = 8'h00;
    idle(3);
    good(8'hF0, 16);

    // Randomised frames, divisors, gaps, framing errors and acks
    for (int it = 0; it < 24; it++) begin
      b    = int'($urandom_range(15, 40));
      d    = 8'($urandom_range(0, 255));
      bad  = ($urandom_range(0, 5) == 0);
      baud = BW'(b);
      idle(int'($urandom_range(2, 20)));
      e0 = cyc;
      if (bad) expect_ferr(b, e0);
      else     expect_good(d, b, e0);
      send_frame(d, !bad, b, e0);
      if (bad) begin
        idle(int'($urandom_range(0, 30)));
        rxd = 1'b1;
        idle(5);
      end
      if ($urandom_range(0, 1) == 1) do_ack();
    end

    idle(20);
    check("pending_events", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
